// File: rtl/fetch_predict_unit.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit counters.
// Branches resolved in ID update the table and redirect fetch on a mispredict.
module fetch_predict_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                ENTRIES  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              flush,
  output logic [31:0]       mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              id_taken_q, id_taken_d;
  logic [ADDR_W-1:0] id_tgt_q, id_tgt_d;
  logic [31:0]       cnt_q, cnt_d;

  // Fetch-side lookup
  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic              f_hit, f_pred;
  logic [ADDR_W-1:0] f_next;

  assign f_idx  = pc_q[IDX_W+1:2];
  assign f_tag  = pc_q[ADDR_W-1:IDX_W+2];
  assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pred = f_hit && ctr_q[f_idx][1];
  assign f_next = f_pred ? tgt_q[f_idx] : pc_q + ADDR_W'(4);

  // Resolve-side lookup
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;
  logic             mispredict;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // The ID register holds the predicted next PC, so on agreeing taken
  // predictions the stored target is the BTB target that was followed.
  assign mispredict = upd_valid &&
                      ((upd_taken != id_taken_q) ||
                       (upd_taken && (upd_target != id_tgt_q)));

  always_comb begin
    u_ctr = ctr_q[u_idx];
    if (upd_taken && u_ctr != 2'b11)
      u_ctr = u_ctr + 2'b01;
    else if (!upd_taken && u_ctr != 2'b00)
      u_ctr = u_ctr - 2'b01;
  end

  always_comb begin
    pc_d       = f_next;
    id_taken_d = id_taken_q;
    id_tgt_d   = id_tgt_q;
    cnt_d      = cnt_q;
    if (mispredict)
      pc_d = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    else if (stall)
      pc_d = pc_q;
    if (mispredict) begin
      id_taken_d = 1'b0;
      id_tgt_d   = '0;
    end else if (!stall) begin
      id_taken_d = f_pred;
      id_tgt_d   = f_next;
    end
    if (mispredict && cnt_q != 32'hFFFF_FFFF)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_taken_q <= 1'b0;
      id_tgt_q   <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      id_taken_q <= id_taken_d;
      id_tgt_q   <= id_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Table updates ignore stall; a miss only allocates on a taken outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr;
        if (upd_taken)
          tgt_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  assign pc             = pc_q;
  assign pred_taken     = f_pred && !reset;
  assign flush          = mispredict && !reset;
  assign mispredict_cnt = cnt_q;

endmodule
